// File: rtl/idct_2d_if.sv
// Block handshake between the dequantizer, idct_2d and the pixel writer.
interface idct_2d_if #(
  parameter int COEF_W = 12
);
  logic                 start;
  logic [64*COEF_W-1:0] coef_in;
  logic                 busy;
  logic                 done;
  logic [511:0]         pix_out;

  // start is a one-cycle request honoured only while busy is low; coef_in is
  // sampled on that edge alone. done pulses once when pix_out holds the new block.
  modport master (output start, coef_in, input busy, done, pix_out);
  modport slave  (input start, coef_in, output busy, done, pix_out);
endinterface

// File: rtl/idct_2d.sv
// 8x8 2D inverse DCT: row pass, transpose, column pass through one 8-point engine.
// Define IDCT_PIPE2_EN to register the engine products (latency 19 instead of 17).
module idct_2d #(
  parameter int COEF_W = 12,
  parameter int MID_W  = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  idct_2d_if.slave   bus,
  output logic [1:0] o_dbg_state
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ROW  = 2'd1;
  localparam logic [1:0] S_COL  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;
`ifdef IDCT_PIPE2_EN
  localparam logic [3:0] FILL = 4'd1;
`else
  localparam logic [3:0] FILL = 4'd0;
`endif
  localparam logic [3:0] LAST    = 4'd7 + FILL;
  localparam int         MID_MAX = (1 << (MID_W - 1)) - 1;
  localparam int         MID_MIN = -(1 << (MID_W - 1));

  logic [1:0]              r_state;
  logic [3:0]              r_cnt;
  logic [64*COEF_W-1:0]    r_coef;
  logic signed [MID_W-1:0] r_tbuf [8][8];
  logic [7:0]              r_stage [8][8];
  logic [511:0]            r_pix;
  logic                    r_done;

  logic [2:0]              w_rd_idx;
  logic [2:0]              w_wr_idx;
  logic                    w_wr_en;
  logic signed [MID_W-1:0] w_vec [8];
  logic signed [31:0]      w_prod [8][8];
  logic signed [31:0]      w_term [8][8];
  logic signed [31:0]      w_acc [8];
  logic signed [MID_W-1:0] w_row_res [8];
  logic [7:0]              w_col_res [8];

  // round(2048*C(k)*cos((2n+1)k*pi/16)) folded onto the first quadrant
  function automatic logic signed [12:0] coef_of(input int n, input int k);
    int                 m;
    logic               neg;
    logic signed [12:0] mag;
    if (k == 0) return 13'sd1448;
    m   = ((2 * n + 1) * k) % 32;
    neg = 1'b0;
    if (m > 16) m = 32 - m;
    if (m > 8) begin
      m   = 16 - m;
      neg = 1'b1;
    end
    case (m)
      1:       mag = 13'sd2009;
      2:       mag = 13'sd1892;
      3:       mag = 13'sd1703;
      4:       mag = 13'sd1448;
      5:       mag = 13'sd1138;
      6:       mag = 13'sd784;
      7:       mag = 13'sd400;
      default: mag = 13'sd0;
    endcase
    return neg ? -mag : mag;
  endfunction

  function automatic logic signed [MID_W-1:0] sat_mid(input logic signed [31:0] a);
    logic signed [31:0] t;
    t = (a + 32'sd256) >>> 9;
    if (t > MID_MAX) return MID_W'(MID_MAX);
    if (t < MID_MIN) return MID_W'(MID_MIN);
    return MID_W'(t);
  endfunction

  function automatic logic [7:0] clamp_pix(input logic signed [31:0] a);
    logic signed [31:0] t;
    t = ((a + 32'sd16384) >>> 15) + 32'sd128;
    if (t < 0)   return 8'd0;
    if (t > 255) return 8'd255;
    return t[7:0];
  endfunction

  assign w_rd_idx = r_cnt[2:0];
  assign w_wr_idx = 3'(r_cnt - FILL);
`ifdef IDCT_PIPE2_EN
  assign w_wr_en  = (r_cnt != 4'd0);
`else
  assign w_wr_en  = 1'b1;
`endif

  // Engine input: a coefficient row in ROW, a transposed buffer column in COL
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      if (r_state == S_COL)
        w_vec[k] = r_tbuf[k][w_rd_idx];
      else
        w_vec[k] = MID_W'($signed(r_coef[(int'(w_rd_idx) * 8 + k) * COEF_W +: COEF_W]));
    end
  end

  always_comb begin
    for (int n = 0; n < 8; n++)
      for (int k = 0; k < 8; k++)
        w_prod[n][k] = 32'(coef_of(n, k)) * 32'(w_vec[k]);
  end

`ifdef IDCT_PIPE2_EN
  logic signed [31:0] r_prod [8][8];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < 8; n++)
        for (int k = 0; k < 8; k++)
          r_prod[n][k] <= '0;
    end else begin
      r_prod <= w_prod;
    end
  end

  always_comb w_term = r_prod;
`else
  always_comb w_term = w_prod;
`endif

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      w_acc[n] = '0;
      for (int k = 0; k < 8; k++)
        w_acc[n] = w_acc[n] + w_term[n][k];
      w_row_res[n] = sat_mid(w_acc[n]);
      w_col_res[n] = clamp_pix(w_acc[n]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_coef  <= '0;
      r_pix   <= '0;
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) begin
          r_tbuf[i][j]  <= '0;
          r_stage[i][j] <= '0;
        end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_coef  <= bus.coef_in;
            r_cnt   <= '0;
            r_state <= S_ROW;
          end
        end
        S_ROW: begin
          if (w_wr_en)
            for (int n = 0; n < 8; n++) r_tbuf[w_wr_idx][n] <= w_row_res[n];
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= S_COL;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_COL: begin
          if (w_wr_en)
            for (int n = 0; n < 8; n++) r_stage[n][w_wr_idx] <= w_col_res[n];
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= S_OUT;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_OUT: begin
          for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
              r_pix[(r * 8 + c) * 8 +: 8] <= r_stage[r][c];
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.pix_out = r_pix;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_idct_2d.sv
// Self-checking bench for idct_2d: table vectors, random blocks vs a real-math model.
`timescale 1ns/1ps
module tb_idct_2d;
  localparam int COEF_W = 12;
  localparam int CW     = 64 * COEF_W;
`ifdef IDCT_PIPE2_EN
  localparam int LAT = 19;
`else
  localparam int LAT = 17;
`endif

  typedef struct {
    logic [CW-1:0] coef;
    logic [511:0]  exp;
  } vec_t;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] dbg_state;

  idct_2d_if #(.COEF_W(COEF_W)) bus ();

  idct_2d #(.COEF_W(COEF_W), .MID_W(16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clock = ~clock;

  int           n_vec = 0;
  int           n_err = 0;
  int           m_coef [8][8];
  logic [511:0] exp_q [$];
  vec_t         vecs [13];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  // Straight from the math: build the cosine table, then two matrix passes
  function automatic logic [511:0] model(input logic [CW-1:0] c);
    longint       y [8][8];
    longint       acc;
    logic [511:0] p;
    p = '0;
    for (int u = 0; u < 8; u++)
      for (int n = 0; n < 8; n++) begin
        acc = 0;
        for (int k = 0; k < 8; k++)
          acc += longint'(m_coef[n][k]) * longint'($signed(c[(u * 8 + k) * COEF_W +: COEF_W]));
        acc = (acc + 256) >>> 9;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        y[u][n] = acc;
      end
    for (int col = 0; col < 8; col++)
      for (int n = 0; n < 8; n++) begin
        acc = 0;
        for (int k = 0; k < 8; k++)
          acc += longint'(m_coef[n][k]) * y[k][col];
        acc = ((acc + 16384) >>> 15) + 128;
        if (acc < 0) acc = 0;
        if (acc > 255) acc = 255;
        p[(n * 8 + col) * 8 +: 8] = 8'(acc);
      end
    return p;
  endfunction

  function automatic logic [CW-1:0] rand_bits();
    logic [CW-1:0] c;
    for (int i = 0; i < CW / 32; i++) c[i * 32 +: 32] = $urandom;
    return c;
  endfunction

  function automatic logic [CW-1:0] rand_lowfreq();
    logic [CW-1:0] c;
    int            v;
    c = '0;
    for (int u = 0; u < 8; u++)
      for (int k = 0; k < 8; k++)
        if (u + k < 4) begin
          v = (u + k == 0) ? int'($urandom_range(0, 2047)) - 1024 : int'($urandom_range(0, 400)) - 200;
          c[(u * 8 + k) * COEF_W +: COEF_W] = 12'(v);
        end
    return c;
  endfunction

  function automatic logic [CW-1:0] one_coef(input int u, input int k, input int v);
    logic [CW-1:0] c;
    c = '0;
    c[(u * 8 + k) * COEF_W +: COEF_W] = 12'(v);
    return c;
  endfunction

  // Drives start at the current negedge; returns at the negedge where done is seen
  // (or after a tail watch when a second start is injected mid-block).
  task automatic run_block(input string tag, input logic [CW-1:0] coef, input logic [511:0] exp,
                           input int repulse_at, input logic [CW-1:0] coef2);
    int           lat;
    int           busy_n;
    int           extra;
    logic [511:0] pix_before;
    logic [511:0] want;
    exp_q.push_back(exp);
    pix_before  = bus.pix_out;
    bus.coef_in = coef;
    bus.start   = 1'b1;
    @(posedge clock);
    #1;
    bus.start   = 1'b0;
    bus.coef_in = rand_bits();
    lat    = -1;
    busy_n = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clock);
      if (i == 0) check({tag, " done_low_after_start"}, 512'(bus.done), 512'(0));
      if (i == LAT - 1) check({tag, " pix_hold"}, bus.pix_out, pix_before);
      if (bus.busy) busy_n++;
      if (i + 1 == repulse_at) begin
        bus.start   = 1'b1;
        bus.coef_in = coef2;
      end else begin
        bus.start   = 1'b0;
        bus.coef_in = rand_bits();
      end
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) $display("FAIL %s: done timeout after %0d cycles", tag, LAT + 10);
    check({tag, " latency"}, 512'(lat), 512'(LAT));
    check({tag, " busy_cycles"}, 512'(busy_n), 512'(LAT));
    want = exp_q.pop_front();
    check({tag, " pix"}, bus.pix_out, want);
    if (repulse_at >= 0) begin
      bus.start = 1'b0;
      extra = 0;
      for (int i = 0; i < LAT + 8; i++) begin
        @(negedge clock);
        if (bus.done) extra++;
      end
      check({tag, " extra_done"}, 512'(extra), 512'(0));
      check({tag, " pix_after"}, bus.pix_out, want);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [CW-1:0] c;
    logic [7:0]    a;
    logic [7:0]    b;
    int            s;

    for (int n = 0; n < 8; n++)
      for (int k = 0; k < 8; k++)
        m_coef[n][k] = rnd(2048.0 * ((k == 0) ? 1.0 / $sqrt(2.0) : 1.0) *
                           $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0));

    bus.start   = 1'b0;
    bus.coef_in = '0;
    reset_n     = 1'b0;
    repeat (3) @(negedge clock);
    check("reset pix", bus.pix_out, '0);
    check("reset done", 512'(bus.done), 512'(0));
    check("reset busy", 512'(bus.busy), 512'(0));
    check("reset state", 512'(dbg_state), 512'(0));
    reset_n = 1'b1;
    @(negedge clock);

    vecs[0] = '{coef: '0,                          exp: {64{8'd128}}};
    vecs[1] = '{coef: one_coef(0, 0, 64),          exp: {64{8'd136}}};
    vecs[2] = '{coef: one_coef(0, 0, -1024),       exp: {64{8'd0}}};
    vecs[3] = '{coef: one_coef(0, 0, 2047),        exp: {64{8'd255}}};
    vecs[4] = '{coef: one_coef(0, 1, 100),         exp: model(one_coef(0, 1, 100))};
    for (int v = 5; v < 13; v++) begin
      c = (v < 11) ? rand_lowfreq() : rand_bits();
      vecs[v] = '{coef: c, exp: model(c)};
    end

    for (int v = 0; v < 13; v++)
      run_block($sformatf("vec%0d", v), vecs[v].coef, vecs[v].exp, -1, '0);

    run_block("ac01", one_coef(0, 1, 100), model(one_coef(0, 1, 100)), -1, '0);
    for (int r = 0; r < 8; r++) begin
      a = bus.pix_out[(r * 8 + 0) * 8 +: 8];
      b = bus.pix_out[(r * 8 + 7) * 8 +: 8];
      check($sformatf("ac01 row%0d edges", r), 512'({a, b}), 512'({8'd145, 8'd111}));
      for (int col = 0; col < 4; col++) begin
        s = int'(bus.pix_out[(r * 8 + col) * 8 +: 8]) + int'(bus.pix_out[(r * 8 + 7 - col) * 8 +: 8]);
        check($sformatf("ac01 row%0d sym%0d", r, col), 512'(s >= 255 && s <= 257), 512'(1));
      end
    end

    c = rand_lowfreq();
    run_block("repulse", c, model(c), 5, rand_lowfreq());

    repeat (3) @(negedge clock);
    c = rand_lowfreq();
    run_block("gap", c, model(c), -1, '0);

    // Abort a block mid-flight with an asynchronous reset
    bus.coef_in = rand_lowfreq();
    bus.start   = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midreset pix", bus.pix_out, '0);
    check("midreset done", 512'(bus.done), 512'(0));
    check("midreset busy", 512'(bus.busy), 512'(0));
    check("midreset state", 512'(dbg_state), 512'(0));
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    run_block("post_reset", one_coef(0, 0, 64), {64{8'd136}}, -1, '0);

    @(negedge clock);
    check("final done_low", 512'(bus.done), 512'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/idct_2d.md
Name: idct_2d

Overview:
- 8x8 two-dimensional inverse DCT for the JPEG decode path; decoder counterpart of the forward 2D DCT.
- Takes one block of dequantized signed coefficients and returns 64 reconstructed 8-bit pixels.
- Runs a row pass then a column pass through one shared 8-point 1D IDCT engine, with a transpose buffer between passes.
- Sits between the dequantizer and the pixel/MCU writer, using a start/busy/done handshake.

Parameters:
- COEF_W, 12, signed coefficient width.
- MID_W, 16, signed width of row-pass results held in the transpose buffer.

Ports:
- clock  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; accepted only in IDLE
- coef_in  in  64*COEF_W  coefficient X[u][v] at bits [(u*8+v)*COEF_W +: COEF_W]; u = vertical frequency, v = horizontal frequency
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse; pix_out is valid from this cycle on
- pix_out  out  512  pixel p[r][c] at bits [(r*8+c)*8 +: 8]; held until the next done

Behaviour:
- Reset (asynchronous): state IDLE, busy=0, done=0, pix_out=0, buffers and counters cleared.
- Reset asserted mid-operation: block aborts, returns to IDLE, and pix_out reads 0.
- Coefficient table: COEF[n][k] = round(2048*C(k)*cos((2n+1)k*pi/16)), with C(0)=1/sqrt2 and C(k>0)=1. Constant table, signed 13-bit; for example COEF[n][0]=1448, COEF[0][1]=2009.
- Accumulator: 32-bit signed sum of 8 products.
- Row pass: for row u, y[u][n] = (sum_k COEF[n][k]*X[u][k] + 256) >>> 9 (3 fraction bits retained), saturated to MID_W signed.
- Column pass: for column c, s[n] = (sum_k COEF[n][k]*y[k][c] + 16384) >>> 15; p[n][c] = clamp(s[n]+128, 0, 255).
- The shift is arithmetic (floor); there is no other rounding.
- FSM states: IDLE, ROW, COL, OUT.
- IDLE: start=1 at edge E0 latches coef_in into the input buffer; go to ROW with idx=0, busy=1.
- ROW: at each edge the engine result for row idx is written to the transpose buffer and idx increments. Rows 0..7 are written at E1..E8; after idx 7, go to COL with idx=0.
- COL: column idx is read transposed from the buffer and the result is written to the output staging buffer. Columns 0..7 are written at E9..E16, then go to OUT.
- OUT: at E17 pix_out is loaded from staging, done=1 for one cycle, busy=0, return to IDLE.
- Latency: done is high in the cycle after E17, i.e. 17 clocks after the start edge.
- start while busy is ignored with no queuing. The coef_in latch makes the input don't-care after E0.
- start in the cycle done is high (state IDLE after E17) is accepted.
- pix_out changes only at the OUT edge or on reset.

Optional Feature:
- Macro IDCT_PIPE2_EN.
- Defined: the engine inserts a product register stage (8 registered products per output), so each pass takes 9 edges including a one-edge pipeline fill. Row writes occur at E2..E9, column writes at E11..E18, done after E19 (latency 19). Arithmetic results are bit-identical.
- Undefined: the engine is single-cycle combinational and latency is 17.

Test Plan:
- All coef_in=0, start pulse -> done 17 cycles later (19 with IDCT_PIPE2_EN); every pixel = 128; busy high for exactly 17 cycles.
- X[0][0]=64, others 0 -> all 64 pixels = 136.
- X[0][0]=-1024 -> all pixels = 0 (low clamp). X[0][0]=2047 -> all pixels = 255 (high clamp).
- X[0][1]=100, others 0 -> every row identical; p[r][0]=145, p[r][7]=111; p[r][c]+p[r][7-c] = 256 ± 1.
- start re-pulsed at E5 with different coef_in -> ignored; output matches the first block; no extra done.
- reset_n low at E10, then start with X[0][0]=64 -> pix_out=0 and done=0 during reset; fresh run produces all 136 with normal latency.
